uart_cmd_sequencer: RTL and testbench

Host-command sequencer between the programmer's UART and its shared memory port (flash/PSRAM controller). Hunts for the 0xDEADBEEF sync word in the received byte stream, parses opcode, 24-bit address and length, then sequences byte-wise memory write, read or erase requests. Returns read data and a one-byte status over the UART transmit handshake. Single-frame, strictly in-order: one command is fully completed before the next sync hunt.

---
 rtl/uart_cmd_pkg.sv | 23 ++
 rtl/uart_cmd_sequencer_timer.sv | 28 ++
 rtl/uart_cmd_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART host-command sequencer.
package uart_cmd_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hDEAD_BEEF;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_ERASE = 8'h03;

    localparam logic [7:0] ST_OK      = 8'hA5;
    localparam logic [7:0] ST_BAD_OP  = 8'hEE;
    localparam logic [7:0] ST_OVERRUN = 8'hE0;
    localparam logic [7:0] ST_TIMEOUT = 8'hE1;

    typedef enum logic [3:0] {
        HUNT, OPC, ADDR, LEN, WR_WAIT, WR_MEM, RD_MEM, RD_TX, ER_MEM, STATUS
    } state_t;

    function automatic logic opcode_valid(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ) || (op == OP_ERASE);
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_timer.sv
// Inter-byte timeout counter: counts enabled idle cycles, flags expiry at TIMEOUT_CYCLES-1.
module cmd_byte_timer #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && (count != LAST))
            count <= count + 1'b1;
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Sync-word framed UART command parser driving byte-wise write/read/erase memory requests.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_erase,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    state_t      state, state_next;
    logic [31:0] shift;
    logic [7:0]  opcode;
    logic [1:0]  addr_idx;
    logic [23:0] addr;
    logic [8:0]  cnt;
    logic [7:0]  hold;
    logic        hold_full;
    logic        overrun;
    logic [7:0]  wdata;
    logic        tx_fire;
    logic [7:0]  tx_byte;
    logic        timer_en;
    logic        expire;
    logic        timeout;

    assign timer_en = (state == OPC) || (state == ADDR) || (state == LEN) || (state == WR_WAIT);
    assign timeout  = expire && !rx_ready;

    cmd_byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (timer_en),
        .clear  (rx_ready || !timer_en),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= HUNT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_fire    = 1'b0;
        tx_byte    = ST_OK;
        case (state)
            HUNT:    if (rx_ready && ({shift[23:0], rx_data} == SYNC_WORD)) state_next = OPC;
            OPC: begin
                if (rx_ready) begin
                    if (opcode_valid(rx_data)) begin
                        state_next = ADDR;
                    end else begin
                        state_next = STATUS;
                        tx_fire    = 1'b1;
                        tx_byte    = ST_BAD_OP;
                    end
                end
            end
            ADDR:    if (rx_ready && (addr_idx == 2'd2)) state_next = LEN;
            LEN: begin
                if (rx_ready) begin
                    if (opcode == OP_WRITE)     state_next = WR_WAIT;
                    else if (opcode == OP_READ) state_next = RD_MEM;
                    else                        state_next = ER_MEM;
                end
            end
            WR_WAIT: if (hold_full || rx_ready) state_next = WR_MEM;
            WR_MEM: begin
                if (mem_ack) begin
                    // An overrun aborts only once the in-flight write has completed.
                    if (overrun || (rx_ready && hold_full)) begin
                        state_next = STATUS;
                        tx_fire    = 1'b1;
                        tx_byte    = ST_OVERRUN;
                    end else if (cnt == 9'd1) begin
                        state_next = STATUS;
                        tx_fire    = 1'b1;
                    end else begin
                        state_next = WR_WAIT;
                    end
                end
            end
            RD_MEM: begin
                if (mem_ack) begin
                    state_next = RD_TX;
                    tx_fire    = 1'b1;
                    tx_byte    = mem_rdata;
                end
            end
            RD_TX: begin
                if (tx_ready) begin
                    if (cnt == 9'd0) begin
                        state_next = STATUS;
                        tx_fire    = 1'b1;
                    end else begin
                        state_next = RD_MEM;
                    end
                end
            end
            ER_MEM: begin
                if (mem_ack) begin
                    state_next = STATUS;
                    tx_fire    = 1'b1;
                end
            end
            STATUS:  if (tx_ready) state_next = HUNT;
            default: state_next = HUNT;
        endcase
        if (timeout) begin
            state_next = STATUS;
            tx_fire    = 1'b1;
            tx_byte    = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift     <= '0;
            opcode    <= '0;
            addr_idx  <= '0;
            addr      <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            overrun   <= 1'b0;
            wdata     <= '0;
            tx_req    <= 1'b0;
            tx_data   <= '0;
        end else begin
            tx_req <= tx_fire;
            if (tx_fire)
                tx_data <= tx_byte;

            if ((state != HUNT) || (state_next != HUNT))
                shift <= '0;
            else if (rx_ready)
                shift <= {shift[23:0], rx_data};

            case (state)
                OPC: begin
                    if (rx_ready)
                        opcode <= rx_data;
                    addr_idx <= '0;
                end
                ADDR: begin
                    if (rx_ready) begin
                        addr     <= {addr[15:0], rx_data};
                        addr_idx <= addr_idx + 2'd1;
                    end
                end
                LEN: begin
                    if (rx_ready)
                        cnt <= {1'b0, rx_data} + 9'd1;
                    hold_full <= 1'b0;
                    overrun   <= 1'b0;
                end
                WR_WAIT: begin
                    // The buffered byte moves to the write-data register; a new byte may refill the buffer.
                    if (hold_full) begin
                        wdata     <= hold;
                        hold_full <= rx_ready;
                        if (rx_ready)
                            hold <= rx_data;
                    end else if (rx_ready) begin
                        wdata <= rx_data;
                    end
                end
                WR_MEM: begin
                    if (rx_ready) begin
                        if (hold_full) begin
                            overrun <= 1'b1;
                        end else begin
                            hold      <= rx_data;
                            hold_full <= 1'b1;
                        end
                    end
                    if (mem_ack) begin
                        addr <= addr + 24'd1;
                        cnt  <= cnt - 9'd1;
                    end
                end
                RD_MEM: begin
                    if (mem_ack) begin
                        addr <= addr + 24'd1;
                        cnt  <= cnt - 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state == WR_MEM) || (state == RD_MEM) || (state == ER_MEM);
    assign mem_we    = (state == WR_MEM);
    assign mem_erase = (state == ER_MEM);
    assign mem_addr  = addr;
    assign mem_wdata = wdata;
    assign busy      = (state != HUNT);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer: directed frames, memory/UART responders as monitors.
module tb_uart_cmd_sequencer;

    typedef struct {
        logic        we;
        logic        erase;
        logic [23:0] addr;
        logic [7:0]  wdata;
    } mem_exp_t;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_erase;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        busy;

    mem_exp_t    exp_mem[$];
    logic [7:0]  exp_tx[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_rx_cyc = 0;
    int          last_tx_cyc = 0;
    int          ack_delay = 0;
    int          tx_pend = 0;
    bq_t         seq;

    uart_cmd_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_erase (mem_erase),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Memory responder and request monitor.
    initial begin
        int       wait_cnt;
        logic     ack_was;
        mem_exp_t e;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        wait_cnt  = 0;
        forever begin
            @(negedge clk);
            ack_was = mem_ack;
            mem_ack = 1'b0;
            if (reset || !mem_req) begin
                wait_cnt = 0;
            end else if (!ack_was) begin
                if (wait_cnt >= ack_delay) begin
                    if (exp_mem.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL mem_unexpected we=%0d erase=%0d addr=%h wdata=%h", mem_we, mem_erase, mem_addr, mem_wdata);
                    end else begin
                        e = exp_mem.pop_front();
                        check("mem_we_erase_addr", {mem_we, mem_erase, mem_addr}, {e.we, e.erase, e.addr});
                        if (e.we)
                            check("mem_wdata", mem_wdata, e.wdata);
                    end
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr[7:0];
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // UART transmitter responder and byte monitor.
    initial begin
        logic [7:0] e;
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            tx_ready = 1'b0;
            if (reset) begin
                tx_pend = 0;
            end else begin
                if (tx_pend > 0) begin
                    tx_pend--;
                    if (tx_pend == 0)
                        tx_ready = 1'b1;
                end
                if (tx_req) begin
                    last_tx_cyc = cyc;
                    if (tx_pend > 0 || tx_ready) begin
                        total++;
                        bad++;
                        $display("FAIL tx_early data=%h pending=%0d", tx_data, tx_pend);
                    end
                    if (exp_tx.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_unexpected got=%h", tx_data);
                    end else begin
                        e = exp_tx.pop_front();
                        check("tx_data", tx_data, e);
                    end
                    tx_pend = 2;
                end
            end
        end
    end

    task automatic send_seq(input bq_t s, input int gap);
        foreach (s[i]) begin
            @(negedge clk);
            rx_data     = s[i];
            rx_ready    = 1'b1;
            last_rx_cyc = cyc + 1;
            @(negedge clk);
            rx_ready = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic push_mem(input logic we, input logic erase, input logic [23:0] a, input logic [7:0] d);
        mem_exp_t e;
        e.we    = we;
        e.erase = erase;
        e.addr  = a;
        e.wdata = d;
        exp_mem.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && (busy || exp_tx.size() != 0 || exp_mem.size() != 0 || tx_pend != 0)) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s_done busy=%0d tx_left=%0d mem_left=%0d want idle", name, busy, exp_tx.size(), exp_mem.size());
        end
        exp_tx.delete();
        exp_mem.delete();
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {mem_req, mem_we, mem_erase, tx_req, busy, mem_addr, mem_wdata, tx_data}, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Four writes, ack in the first request cycle.
        ack_delay = 0;
        for (int i = 0; i < 4; i++)
            push_mem(1'b1, 1'b0, 24'(i), 8'(8'h11 * (i + 1)));
        exp_tx.push_back(8'hA5);
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
        send_seq(seq, 2);
        wait_done("write4", 300);

        // Overlapping sync, reads wrapping the 24-bit address.
        ack_delay = 3;
        push_mem(1'b0, 1'b0, 24'hFFFFFE, 8'h00);
        push_mem(1'b0, 1'b0, 24'hFFFFFF, 8'h00);
        push_mem(1'b0, 1'b0, 24'h000000, 8'h00);
        exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'hA5);
        seq = '{8'hDE, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h02, 8'hFF, 8'hFF, 8'hFE, 8'h02};
        send_seq(seq, 1);
        wait_done("read_wrap", 300);

        // Bad opcode, trailing bytes treated as noise.
        exp_tx.push_back(8'hEE);
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h07, 8'h00, 8'h00, 8'h00, 8'h03};
        send_seq(seq, 1);
        wait_done("bad_opcode", 100);
        check("bad_opcode_busy", busy, 0);

        // Silence after the first address byte.
        exp_tx.push_back(8'hE1);
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h00};
        send_seq(seq, 1);
        wait_done("timeout", 300);
        check("timeout_latency", 64'(last_tx_cyc - last_rx_cyc), 64'd100);
        check("timeout_busy", busy, 0);

        // Slow memory with back-to-back payload: second byte buffered, third overruns.
        ack_delay = 50;
        push_mem(1'b1, 1'b0, 24'h000010, 8'hA1);
        exp_tx.push_back(8'hE0);
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h00, 8'h00, 8'h10, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_seq(seq, 1);
        wait_done("overrun", 400);

        // Reset while a read request is outstanding, then an erase frame.
        ack_delay = 1000;
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h02, 8'h00, 8'h12, 8'h34, 8'h00};
        send_seq(seq, 1);
        repeat (4) @(negedge clk);
        check("rd_req_pending", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 24'h001234});
        #2 reset = 1'b1;
        #1 check("reset_async", {mem_req, mem_we, mem_erase, tx_req, busy, mem_addr, mem_wdata, tx_data}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ack_delay = 2;
        push_mem(1'b0, 1'b1, 24'h002000, 8'h00);
        exp_tx.push_back(8'hA5);
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h03, 8'h00, 8'h20, 8'h00, 8'h05};
        send_seq(seq, 1);
        wait_done("erase", 200);
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
